// File: rtl/traffic_light_multi.sv
// N-phase intersection controller: GREEN->YELLOW->ALL_RED round-robin paced by pulse_1s,
// with emergency preemption, flashing-red outage mode and optional walk lamps (`PED_WALK_EN).
module traffic_light_multi #(
  parameter int NUM_PH   = 3,
  parameter int PH_W     = 3,
  parameter int TMR_W    = 6,
  parameter int GREEN_S  = 10,
  parameter int YELLOW_S = 5,
  parameter int ALLRED_S = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pulse_1s,
  input  logic              nmi_emergency_vehicle,
  input  logic [PH_W-1:0]   emg_phase,
  input  logic              nmi_power_outage,
  input  logic [NUM_PH-1:0] ped_req,
  output logic [NUM_PH-1:0] light_green,
  output logic [NUM_PH-1:0] light_yellow,
  output logic [NUM_PH-1:0] light_red,
  output logic [NUM_PH-1:0] ped_walk,
  output logic [PH_W-1:0]   cur_phase
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_GREEN  = 3'd1;
  localparam logic [2:0] S_YELLOW = 3'd2;
  localparam logic [2:0] S_ALLRED = 3'd3;
  localparam logic [2:0] S_FLASH  = 3'd4;

  logic [2:0]        st, st_d;
  logic [PH_W-1:0]   ph_d;
  logic [TMR_W-1:0]  timer, timer_d, load_val;
  logic              load, flash_togl, emg_vld, entering_green;
  logic [NUM_PH-1:0] green_d, yellow_d, red_d, ph_oh;

  // Out-of-range emergency phases are treated as no request at all.
  assign emg_vld = nmi_emergency_vehicle && ({1'b0, emg_phase} < (PH_W+1)'(NUM_PH));
  assign ph_oh   = {{(NUM_PH-1){1'b0}}, 1'b1} << ph_d;
  assign entering_green = (st_d == S_GREEN) && (st != S_GREEN);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st           <= S_RESET;
      cur_phase    <= '0;
      timer        <= '0;
      flash_togl   <= 1'b0;
      light_green  <= '0;
      light_yellow <= '0;
      light_red    <= '0;
    end else if (pulse_1s) begin
      st           <= st_d;
      cur_phase    <= ph_d;
      timer        <= timer_d;
      flash_togl   <= ~flash_togl;
      light_green  <= green_d;
      light_yellow <= yellow_d;
      light_red    <= red_d;
    end
  end

  always_comb begin
    st_d     = st;
    ph_d     = cur_phase;
    load     = 1'b0;
    load_val = '0;
    if (st != S_RESET && nmi_power_outage) begin
      st_d = S_FLASH;
    end else begin
      case (st)
        S_RESET: begin
          st_d = S_GREEN; ph_d = '0; load = 1'b1; load_val = TMR_W'(GREEN_S);
        end
        S_GREEN:
          if (!(emg_vld && emg_phase == cur_phase) && (timer == '0 || emg_vld)) begin
            st_d = S_YELLOW; load = 1'b1; load_val = TMR_W'(YELLOW_S);
          end
        S_YELLOW:
          if (timer == '0) begin
            st_d = S_ALLRED; load = 1'b1; load_val = TMR_W'(ALLRED_S);
          end
        S_ALLRED:
          if (timer == '0) begin
            st_d = S_GREEN; load = 1'b1; load_val = TMR_W'(GREEN_S);
            if (emg_vld)                              ph_d = emg_phase;
            else if (cur_phase == PH_W'(NUM_PH - 1)) ph_d = '0;
            else                                      ph_d = cur_phase + 1'b1;
          end
        S_FLASH: begin
          st_d = S_ALLRED; load = 1'b1; load_val = TMR_W'(ALLRED_S);
        end
        default: st_d = S_RESET;
      endcase
    end
    if (load)              timer_d = load_val;
    else if (timer != '0)  timer_d = timer - 1'b1;
    else                   timer_d = timer;
  end

  // Lamps are decoded from the state being entered, so they change on the same pulse.
  always_comb begin
    green_d  = '0;
    yellow_d = '0;
    red_d    = '0;
    case (st_d)
      S_GREEN:  begin green_d  = ph_oh; red_d = ~ph_oh; end
      S_YELLOW: begin yellow_d = ph_oh; red_d = ~ph_oh; end
      S_ALLRED: red_d = '1;
      S_FLASH:  red_d = {NUM_PH{~flash_togl}};
      default:  red_d = '0;
    endcase
  end

`ifdef PED_WALK_EN
  logic [NUM_PH-1:0] latch, clr, walk_d;

  assign clr = (pulse_1s && entering_green) ? ph_oh : '0;

  always_comb begin
    walk_d = '0;
    if (st_d == S_GREEN) walk_d = entering_green ? (ph_oh & latch) : ped_walk;
  end

  // Requests seen on the serving edge stay latched for the next service of that phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      latch    <= '0;
      ped_walk <= '0;
    end else begin
      latch <= (latch & ~clr) | ped_req;
      if (pulse_1s) ped_walk <= walk_d;
    end
  end
`else
  logic unused_ped;
  assign unused_ped = ^ped_req ^ entering_green;
  assign ped_walk   = '0;
`endif

endmodule

// File: tb/tb_traffic_light_multi.sv
// Bench for traffic_light_multi: vector table, directed corner sequences and a randomized run
// against a pulse-level behavioural model.
module tb_traffic_light_multi;
  localparam int NP = 3, GS = 4, YS = 2, AS = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0, pulse_1s = 1'b0, nmi_emergency_vehicle = 1'b0, nmi_power_outage = 1'b0;
  logic [2:0] emg_phase = '0, ped_req = '0;
  logic [2:0] light_green, light_yellow, light_red, ped_walk, cur_phase;

  traffic_light_multi #(.NUM_PH(NP), .PH_W(3), .TMR_W(6), .GREEN_S(GS), .YELLOW_S(YS), .ALLRED_S(AS)) dut (
    .clk(clk), .reset_n(reset_n), .pulse_1s(pulse_1s),
    .nmi_emergency_vehicle(nmi_emergency_vehicle), .emg_phase(emg_phase),
    .nmi_power_outage(nmi_power_outage), .ped_req(ped_req),
    .light_green(light_green), .light_yellow(light_yellow), .light_red(light_red),
    .ped_walk(ped_walk), .cur_phase(cur_phase));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit       r_emg = 0, r_out = 0;
  bit [2:0] r_ep = 0;

  // Model: mode 0 idle, 1 green, 2 yellow, 3 all-red, 4 flashing; left = seconds remaining.
  int       m_mode = 0, m_ph = 0, m_left = 0;
  bit       m_tog = 0;
  bit [2:0] m_latch = 0, m_walk = 0;

  typedef struct { bit rn; bit [2:0] g, y, r; int ph; } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    int  nm, load;
    bit  ev;
    if (!reset_n) begin
      m_mode = 0; m_ph = 0; m_left = 0; m_tog = 0; m_latch = 0; m_walk = 0;
      return;
    end
    if (pulse_1s) begin
      ev = nmi_emergency_vehicle && (emg_phase < NP);
      m_tog = ~m_tog;
      nm = m_mode; load = -1;
      if (m_mode != 0 && nmi_power_outage) nm = 4;
      else if (m_mode == 0) begin nm = 1; m_ph = 0; load = GS; end
      else if (m_mode == 1) begin
        if (!(ev && emg_phase == m_ph) && (m_left == 0 || ev)) begin nm = 2; load = YS; end
      end else if (m_mode == 2) begin
        if (m_left == 0) begin nm = 3; load = AS; end
      end else if (m_mode == 3) begin
        if (m_left == 0) begin nm = 1; load = GS; m_ph = ev ? int'(emg_phase) : (m_ph + 1) % NP; end
      end else begin nm = 3; load = AS; end
      if (load >= 0) m_left = load;
      else if (m_left > 0) m_left--;
`ifdef PED_WALK_EN
      if (nm == 1 && m_mode != 1) begin
        m_walk = m_latch[m_ph] ? 3'(1 << m_ph) : 3'b000;
        m_latch[m_ph] = 1'b0;
      end else if (nm != 1) m_walk = 0;
`endif
      m_mode = nm;
    end
`ifdef PED_WALK_EN
    m_latch |= ped_req;
`endif
  endtask

  task automatic check_model();
    bit [2:0] g = 0, y = 0, r = 0, oh;
    oh = 3'(1 << m_ph);
    case (m_mode)
      1: begin g = oh; r = ~oh; end
      2: begin y = oh; r = ~oh; end
      3: r = 3'b111;
      4: r = m_tog ? 3'b111 : 3'b000;
      default: r = 0;
    endcase
    chk("model g/y/r/walk/phase", {light_green, light_yellow, light_red, ped_walk, cur_phase},
        {g, y, r, m_walk, 3'(m_ph)});
  endtask

  task automatic step(input bit rn, input bit pls, input bit [2:0] ped);
    @(negedge clk);
    reset_n = rn; pulse_1s = pls; ped_req = ped;
    nmi_emergency_vehicle = r_emg; emg_phase = r_ep; nmi_power_outage = r_out;
    @(posedge clk);
    model_edge();
    #1 check_model();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 0, 3'b000);
  endtask

  task automatic pulse(input int n = 1);
    repeat (n) begin step(1, 1, 3'b000); idle(9); end
  endtask

  task automatic do_reset();
    r_emg = 0; r_out = 0; r_ep = 0;
    step(0, 0, 3'b000);
  endtask

  initial begin
    tbl[0] = '{0, 3'b000, 3'b000, 3'b000, 0};
    for (int i = 1; i <= 5; i++) tbl[i] = '{1, 3'b001, 3'b000, 3'b110, 0};
    for (int i = 6; i <= 8; i++) tbl[i] = '{1, 3'b000, 3'b001, 3'b110, 0};
    tbl[9]  = '{1, 3'b000, 3'b000, 3'b111, 0};
    tbl[10] = '{1, 3'b000, 3'b000, 3'b111, 0};
    tbl[11] = '{1, 3'b010, 3'b000, 3'b101, 1};

    step(0, 1, 3'b000);
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rn) step(1, 1, 3'b000); else step(0, 0, 3'b000);
      chk($sformatf("vec%0d lamps", i), {light_green, light_yellow, light_red}, {tbl[i].g, tbl[i].y, tbl[i].r});
      chk($sformatf("vec%0d phase", i), cur_phase, tbl[i].ph);
      idle(9);
    end
    pulse(10);
    chk("wrap to phase 2", {light_green, cur_phase}, {3'b100, 3'd2});
    pulse(10);
    chk("wrap back to phase 0", {light_green, cur_phase}, {3'b001, 3'd0});

    idle(100);
    chk("frozen without pulses", {light_green, cur_phase}, {3'b001, 3'd0});

    // Emergency toward another phase cuts green, then overrides round-robin.
    do_reset(); pulse();
    r_emg = 1; r_ep = 2; pulse();
    chk("emg cuts green", {light_green, light_yellow}, {3'b000, 3'b001});
    pulse(4); pulse();
    chk("emg serves phase 2", {light_green, cur_phase}, {3'b100, 3'd2});
    pulse(20);
    chk("emg holds green", light_green, 3'b100);
    r_emg = 0; pulse();
    chk("release -> yellow", {light_green, light_yellow}, {3'b000, 3'b100});

    // Outage during yellow of phase 1.
    do_reset(); pulse(16);
    chk("yellow phase 1", light_yellow, 3'b010);
    r_out = 1; pulse();
    chk("flash on", {light_green, light_yellow, light_red}, {3'b000, 3'b000, 3'b111});
    pulse();
    chk("flash off", {light_green, light_yellow, light_red}, {3'b000, 3'b000, 3'b000});
    r_out = 0; pulse(2);
    chk("all-red after outage", {light_green, light_red}, {3'b000, 3'b111});
    pulse();
    chk("green 2 after outage", {light_green, cur_phase}, {3'b100, 3'd2});

    // Pedestrian request for phase 1 during GREEN(0).
    do_reset(); pulse();
    step(1, 0, 3'b010);
    pulse(9);
    chk("walk idle before service", ped_walk, 3'b000);
    pulse();
`ifdef PED_WALK_EN
    chk("walk during green 1", ped_walk, 3'b010);
`else
    chk("walk tied off", ped_walk, 3'b000);
`endif
    pulse(5);
    chk("walk off after green 1", ped_walk, 3'b000);

    do_reset(); pulse(); idle(3);
    step(0, 0, 3'b000);
    chk("reset mid-green", {light_green, light_yellow, light_red, ped_walk, cur_phase}, 15'd0);

    // Randomized run.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) r_emg = ~r_emg;
      if ($urandom_range(0, 3) == 0) r_ep = 3'($urandom_range(0, 7));
      if (!r_out && $urandom_range(0, 24) == 0) r_out = 1;
      else if (r_out && $urandom_range(0, 3) == 0) r_out = 0;
      step($urandom_range(0, 149) != 0, 1, ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
      for (int k = $urandom_range(0, 3); k > 0; k--)
        step(1, 0, ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
